// File: rtl/clz_scan_ctrl.sv
// Multi-cycle leading-zero normaliser: walks the operand MSB-first one chunk per
// cycle through a shared external CHUNK-bit CLZ unit, then left-normalises it.
module clz_scan_ctrl #(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = $clog2(WIDTH) + 1,
  localparam int LW     = $clog2(CHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [CHUNK-1:0] clz_in,
  input  logic [LW-1:0]    clz_cnt,
  input  logic             clz_nz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero,
  output logic             busy
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [CW-1:0]    count_reg;
  logic [IW-1:0]    idx_reg;
  logic             zero_reg;

  // The working register doubles as the result: after the final shift it holds
  // the normalised operand, so no separate output copy is needed.
  assign clz_in    = work_reg[WIDTH-1 -: CHUNK];
  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_count = count_reg;
  assign out_norm  = work_reg;
  assign out_zero  = zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      count_reg <= '0;
      idx_reg   <= '0;
      zero_reg  <= 1'b0;
    end else if (flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= in_data;
            count_reg <= '0;
            idx_reg   <= '0;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (clz_nz) begin
            count_reg <= count_reg + {{(CW-LW){1'b0}}, clz_cnt};
            work_reg  <= work_reg << clz_cnt;
            zero_reg  <= 1'b0;
            state_reg <= DONE;
          end else if (idx_reg == IW'(NCHUNK - 1)) begin
            // Last chunk also empty: the whole operand is zero.
            count_reg <= CW'(WIDTH);
            work_reg  <= '0;
            zero_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            count_reg <= count_reg + CW'(CHUNK);
            work_reg  <= work_reg << CHUNK;
            idx_reg   <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
